// File: rtl/npu_pool_act.sv
// Post-MAC activation path: bias add with saturation, max/average pooling with optional ReLU,
// and a small write buffer that streams pooled results to activation memory.
module npu_pool_act #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  layer_start,
    input  logic [2:0]            cfg_pool_len,
    input  logic                  cfg_avg,
    input  logic                  cfg_relu,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic                  mac_valid,
    input  logic [DATA_WIDTH-1:0] mac_out,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  in_ready,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ack,
    output logic                  act_overflow,
    output logic [7:0]            ovf_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EXT_W = DATA_WIDTH + 1;
    localparam int unsigned SUM_W = DATA_WIDTH + 2;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 3);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_entry_t;

    logic [1:0]            shift_q, shift_d;
    logic                  avg_q, relu_q;
    logic [ADDR_WIDTH-1:0] base_q;

    logic                  accept_c;
    logic [EXT_W-1:0]      raw_sum_c;
    logic                  pos_ovf_c, neg_ovf_c, sat_evt_c;
    logic [DATA_WIDTH-1:0] sat_val_c;
    logic                  s1_vld_q;
    logic signed [DATA_WIDTH-1:0] s1_q;

    logic [1:0]                   win_q, last_idx_c;
    logic signed [DATA_WIDTH-1:0] max_q, max_nx_c, pool_c;
    logic signed [SUM_W-1:0]      sum_q, sum_nx_c, s1_ext_c;
    logic [ADDR_WIDTH-1:0]        out_cnt_q;
    logic                         first_c, last_c, step_c, push_c;
    logic [DATA_WIDTH-1:0]        res_c;
    wr_entry_t                    push_entry_c;

    logic                  ovf_q;
    logic [7:0]            ovf_cnt_q;

    wr_entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  pop_c;
    wr_entry_t             head_c;

    // Pool length encoded as log2; illegal lengths fall back to 1.
    always_comb begin
        shift_d = 2'd0;
        case (cfg_pool_len)
            3'd2:    shift_d = 2'd1;
            3'd4:    shift_d = 2'd2;
            default: shift_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= 2'd0;
            avg_q   <= 1'b0;
            relu_q  <= 1'b0;
            base_q  <= '0;
        end else if (layer_start) begin
            shift_q <= shift_d;
            avg_q   <= cfg_avg;
            relu_q  <= cfg_relu;
            base_q  <= cfg_base_addr;
        end
    end

    // Stage 1: bias add, clamped to the signed data range.
    always_comb begin
        accept_c  = mac_valid & in_ready;
        raw_sum_c = {mac_out[DATA_WIDTH-1], mac_out} + {bias[DATA_WIDTH-1], bias};
        pos_ovf_c = (raw_sum_c[EXT_W-1:EXT_W-2] == 2'b01);
        neg_ovf_c = (raw_sum_c[EXT_W-1:EXT_W-2] == 2'b10);
        sat_evt_c = accept_c & (pos_ovf_c | neg_ovf_c);
        sat_val_c = raw_sum_c[DATA_WIDTH-1:0];
        if (pos_ovf_c) begin
            sat_val_c = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (neg_ovf_c) begin
            sat_val_c = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q <= 1'b0;
            s1_q     <= '0;
        end else begin
            s1_vld_q <= accept_c;
            if (accept_c) begin
                s1_q <= sat_val_c;
            end
        end
    end

    // Stage 2: window accumulate; a layer_start drops the sample sitting in stage 1.
    always_comb begin
        last_idx_c = 2'((3'd1 << shift_q) - 3'd1);
        first_c    = (win_q == 2'd0);
        last_c     = (win_q == last_idx_c);
        step_c     = s1_vld_q & ~layer_start;
        push_c     = step_c & last_c;
        s1_ext_c   = {{(SUM_W-DATA_WIDTH){s1_q[DATA_WIDTH-1]}}, s1_q};

        max_nx_c = s1_q;
        if (!first_c && (max_q > s1_q)) begin
            max_nx_c = max_q;
        end
        sum_nx_c = s1_ext_c;
        if (!first_c) begin
            sum_nx_c = sum_q + s1_ext_c;
        end

        pool_c = avg_q ? DATA_WIDTH'(sum_nx_c >>> shift_q) : max_nx_c;
        res_c  = (relu_q && pool_c[DATA_WIDTH-1]) ? '0 : pool_c;

        push_entry_c.addr = base_q + out_cnt_q;
        push_entry_c.data = res_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q     <= 2'd0;
            max_q     <= '0;
            sum_q     <= '0;
            out_cnt_q <= '0;
        end else if (layer_start) begin
            win_q     <= 2'd0;
            out_cnt_q <= '0;
        end else if (step_c) begin
            max_q <= max_nx_c;
            sum_q <= sum_nx_c;
            if (last_c) begin
                win_q     <= 2'd0;
                out_cnt_q <= out_cnt_q + ADDR_WIDTH'(1);
            end else begin
                win_q <= win_q + 2'd1;
            end
        end
    end

    // Saturation bookkeeping restarts with each layer, counting a saturating first sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else if (layer_start) begin
            ovf_q     <= sat_evt_c;
            ovf_cnt_q <= 8'(sat_evt_c);
        end else if (sat_evt_c) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
        end
    end

    // Write buffer; in_ready keeps two slots free so pushes never meet a full buffer.
    assign pop_c = wr_ack & (cnt_q != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_c) begin
                mem_q[wptr_q] <= push_entry_c;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_comb begin
        head_c = mem_q[rptr_q];
    end

    assign in_ready     = (cnt_q <= READY_MAX);
    assign wr_req       = (cnt_q != '0);
    assign wr_addr      = head_c.addr;
    assign wr_data      = head_c.data;
    assign act_overflow = ovf_q;
    assign ovf_cnt      = ovf_cnt_q;

endmodule
